// File: rtl/wb_regfile.sv
// Writeback register file: commits execute-stage results to a 16 x 32-bit
// register array or to the program counter. Long-multiply results are split
// into two consecutive register writes by a two-state sequencer. Two
// combinational read ports with write-first bypass feed operand selection.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int PC_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [1:0]        wb_sel,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [ADDR_W-1:0] wb_rd_hi,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [DATA_W-1:0] wb_data_hi,
    input  logic              pc_advance,
    input  logic [ADDR_W-1:0] rn_addr,
    input  logic [ADDR_W-1:0] rs_addr,
    output logic [DATA_W-1:0] rn_data,
    output logic [DATA_W-1:0] rs_data,
    output logic [PC_W-1:0]   pc_out,
    output logic              busy,
    output logic              illegal_sel
);

    localparam int NREGS = 1 << ADDR_W;

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_LMUL = 2'b01;
    localparam logic [1:0] SEL_JUMP = 2'b10;
    localparam logic [1:0] SEL_ILL  = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        WR_HI = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic                accept;
    logic [DATA_W-1:0]   regs [NREGS];
    logic [DATA_W-1:0]   hi_data_p1;
    logic [ADDR_W-1:0]   hi_rd_p1;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [PC_W-1:0]     pc_q;
    logic                illegal_q;

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, handshake and the single register write port selection
    always_comb begin
        state_d  = state_q;
        wb_ready = 1'b0;
        busy     = 1'b0;
        accept   = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = wb_rd;
        wr_data  = wb_data;
        case (state_q)
            IDLE: begin
                wb_ready = 1'b1;
                accept   = wb_valid;
                if (wb_valid && (wb_sel == SEL_ALU || wb_sel == SEL_LMUL)) begin
                    wr_en = 1'b1;
                end
                if (wb_valid && wb_sel == SEL_LMUL) begin
                    state_d = WR_HI;
                end
            end
            WR_HI: begin
                // Requests are ignored here; the hi half owns the write port.
                busy    = 1'b1;
                wr_en   = 1'b1;
                wr_addr = hi_rd_p1;
                wr_data = hi_data_p1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Register array write; reset clears every entry
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Latch the hi half of a long multiply for the following cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_data_p1 <= '0;
            hi_rd_p1   <= '0;
        end else if (accept && wb_sel == SEL_LMUL) begin
            hi_data_p1 <= wb_data_hi;
            hi_rd_p1   <= wb_rd_hi;
        end
    end

    // Program counter: an accepted jump takes priority over advancing
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= '0;
        end else if (accept && wb_sel == SEL_JUMP) begin
            pc_q <= wb_data[PC_W-1:0];
        end else if (pc_advance) begin
            pc_q <= pc_q + {{(PC_W-1){1'b0}}, 1'b1};
        end
    end

    // One-cycle flag following an accepted illegal selector
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= accept && (wb_sel == SEL_ILL);
        end
    end

    // Read ports return the data being committed this edge when addresses match
    always_comb begin
        rn_data = regs[rn_addr];
        rs_data = regs[rs_addr];
        if (wr_en && wr_addr == rn_addr) begin
            rn_data = wr_data;
        end
        if (wr_en && wr_addr == rs_addr) begin
            rs_data = wr_data;
        end
    end

    assign pc_out      = pc_q;
    assign illegal_sel = illegal_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Testbench for wb_regfile: scenario tasks drive the writeback interface at the
// falling edge; expected register contents go into a scoreboard queue when a
// write is driven and are popped and compared through the read ports later.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic        wb_ready;
    logic [1:0]  wb_sel;
    logic [3:0]  wb_rd;
    logic [3:0]  wb_rd_hi;
    logic [31:0] wb_data;
    logic [31:0] wb_data_hi;
    logic        pc_advance;
    logic [3:0]  rn_addr;
    logic [3:0]  rs_addr;
    logic [31:0] rn_data;
    logic [31:0] rs_data;
    logic [15:0] pc_out;
    logic        busy;
    logic        illegal_sel;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
    } sb_t;

    sb_t         sb_q[$];
    logic [31:0] model[16];
    logic [15:0] exp_pc;
    int          checks = 0;
    int          errors = 0;

    wb_regfile dut (
        .clk         (clk),
        .rst         (rst),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_sel      (wb_sel),
        .wb_rd       (wb_rd),
        .wb_rd_hi    (wb_rd_hi),
        .wb_data     (wb_data),
        .wb_data_hi  (wb_data_hi),
        .pc_advance  (pc_advance),
        .rn_addr     (rn_addr),
        .rs_addr     (rs_addr),
        .rn_data     (rn_data),
        .rs_data     (rs_data),
        .pc_out      (pc_out),
        .busy        (busy),
        .illegal_sel (illegal_sel)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic push_exp(input logic [3:0] a, input logic [31:0] d);
        sb_t e;
        e.addr = a;
        e.data = d;
        sb_q.push_back(e);
        model[a] = d;
    endtask

    task automatic test_reset();
        rst = 1'b1; wb_valid = 1'b0; wb_sel = 2'b00; wb_rd = '0; wb_rd_hi = '0;
        wb_data = '0; wb_data_hi = '0; pc_advance = 1'b0; rn_addr = '0; rs_addr = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_pc = '0;
        for (int i = 0; i < 16; i++) model[i] = '0;
        #1;
        checks += 4;
        if (pc_out !== 16'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc_out, 16'h0); end
        if (wb_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", wb_ready); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (illegal_sel !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b expected 0", illegal_sel); end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            rn_addr = 4'(i);
            rs_addr = 4'(15 - i);
            #1;
            checks += 2;
            if (rn_data !== 32'h0) begin errors++; $display("FAIL reset_rn[%0d]: got %h expected %h", i, rn_data, 32'h0); end
            if (rs_data !== 32'h0) begin errors++; $display("FAIL reset_rs[%0d]: got %h expected %h", 15 - i, rs_data, 32'h0); end
        end
    endtask

    task automatic test_alu_write();
        sb_t e;
        @(negedge clk);
        wb_valid = 1'b1; wb_sel = 2'b00; wb_rd = 4'd5; wb_data = 32'hDEADBEEF;
        rn_addr = 4'd5; rs_addr = 4'd6;
        #1;
        checks += 3;
        if (rn_data !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_bypass: got %h expected %h", rn_data, 32'hDEADBEEF); end
        if (rs_data !== model[6]) begin errors++; $display("FAIL alu_other_port: got %h expected %h", rs_data, model[6]); end
        if (wb_ready !== 1'b1) begin errors++; $display("FAIL alu_ready: got %b expected 1", wb_ready); end
        push_exp(4'd5, 32'hDEADBEEF);
        // back-to-back single-cycle writes
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            wb_valid = 1'b1; wb_sel = 2'b00; wb_rd = 4'(8 + k); wb_data = $urandom;
            #1;
            checks++;
            if (wb_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b expected 1", k, wb_ready); end
            push_exp(4'(8 + k), wb_data);
        end
        // an unqualified request must neither write nor bypass
        @(negedge clk);
        wb_valid = 1'b0; wb_sel = 2'b00; wb_rd = 4'd1; wb_data = 32'h55555555;
        rn_addr = 4'd1;
        #1;
        checks++;
        if (rn_data !== model[1]) begin errors++; $display("FAIL novalid_bypass: got %h expected %h", rn_data, model[1]); end
        push_exp(4'd1, model[1]);
        while (sb_q.size() > 0) begin
            @(negedge clk);
            e = sb_q.pop_front();
            rn_addr = e.addr; rs_addr = e.addr;
            #1;
            checks += 2;
            if (rn_data !== e.data) begin errors++; $display("FAIL alu_rn[%0d]: got %h expected %h", e.addr, rn_data, e.data); end
            if (rs_data !== e.data) begin errors++; $display("FAIL alu_rs[%0d]: got %h expected %h", e.addr, rs_data, e.data); end
        end
    endtask

    task automatic test_long_mul();
        sb_t e;
        @(negedge clk);
        wb_valid = 1'b1; wb_sel = 2'b01; wb_rd = 4'd2; wb_rd_hi = 4'd3;
        wb_data = 32'h11111111; wb_data_hi = 32'h22222222;
        rn_addr = 4'd2; rs_addr = 4'd3;
        #1;
        checks += 4;
        if (rn_data !== 32'h11111111) begin errors++; $display("FAIL lmul_lo_bypass: got %h expected %h", rn_data, 32'h11111111); end
        if (rs_data !== model[3]) begin errors++; $display("FAIL lmul_hi_early: got %h expected %h", rs_data, model[3]); end
        if (busy !== 1'b0) begin errors++; $display("FAIL lmul_busy0: got %b expected 0", busy); end
        if (wb_ready !== 1'b1) begin errors++; $display("FAIL lmul_ready0: got %b expected 1", wb_ready); end
        push_exp(4'd2, 32'h11111111);
        push_exp(4'd3, 32'h22222222);
        // WR_HI cycle: a different request on the bus must be ignored
        @(negedge clk);
        wb_sel = 2'b00; wb_rd = 4'd7; wb_data = 32'hBAD0BAD0;
        #1;
        checks += 4;
        if (busy !== 1'b1) begin errors++; $display("FAIL lmul_busy1: got %b expected 1", busy); end
        if (wb_ready !== 1'b0) begin errors++; $display("FAIL lmul_ready1: got %b expected 0", wb_ready); end
        if (rn_data !== 32'h11111111) begin errors++; $display("FAIL lmul_lo_reg: got %h expected %h", rn_data, 32'h11111111); end
        if (rs_data !== 32'h22222222) begin errors++; $display("FAIL lmul_hi_bypass: got %h expected %h", rs_data, 32'h22222222); end
        push_exp(4'd7, model[7]);
        @(negedge clk);
        wb_valid = 1'b0;
        #1;
        checks += 2;
        if (wb_ready !== 1'b1) begin errors++; $display("FAIL lmul_ready2: got %b expected 1", wb_ready); end
        if (busy !== 1'b0) begin errors++; $display("FAIL lmul_busy2: got %b expected 0", busy); end
        // same register for both halves ends holding hi
        @(negedge clk);
        wb_valid = 1'b1; wb_sel = 2'b01; wb_rd = 4'd9; wb_rd_hi = 4'd9;
        wb_data = 32'hAAAA0001; wb_data_hi = 32'hBBBB0002;
        @(negedge clk);
        wb_valid = 1'b0;
        push_exp(4'd9, 32'hBBBB0002);
        while (sb_q.size() > 0) begin
            @(negedge clk);
            e = sb_q.pop_front();
            rn_addr = e.addr; rs_addr = e.addr;
            #1;
            checks++;
            if (rn_data !== e.data) begin errors++; $display("FAIL lmul_reg[%0d]: got %h expected %h", e.addr, rn_data, e.data); end
        end
    endtask

    task automatic test_pc();
        sb_t e;
        @(negedge clk);
        wb_valid = 1'b1; wb_sel = 2'b10; wb_rd = 4'd4; wb_data = 32'h0000FFFF;
        exp_pc = 16'hFFFF;
        push_exp(4'd4, model[4]);
        @(negedge clk);
        wb_valid = 1'b0;
        #1;
        checks++;
        if (pc_out !== exp_pc) begin errors++; $display("FAIL pc_jump_ffff: got %h expected %h", pc_out, exp_pc); end
        pc_advance = 1'b1;
        exp_pc = 16'h0000;
        @(negedge clk);
        pc_advance = 1'b0;
        #1;
        checks++;
        if (pc_out !== exp_pc) begin errors++; $display("FAIL pc_wrap: got %h expected %h", pc_out, exp_pc); end
        wb_valid = 1'b1; wb_sel = 2'b10; wb_data = 32'h00011234; pc_advance = 1'b1;
        exp_pc = 16'h1234;
        @(negedge clk);
        wb_valid = 1'b0; pc_advance = 1'b0;
        #1;
        checks++;
        if (pc_out !== exp_pc) begin errors++; $display("FAIL pc_jump_wins: got %h expected %h", pc_out, exp_pc); end
        // advance continues through the WR_HI cycle
        wb_valid = 1'b1; wb_sel = 2'b01; wb_rd = 4'd10; wb_rd_hi = 4'd11;
        wb_data = 32'hCAFE0010; wb_data_hi = 32'hCAFE0011; pc_advance = 1'b1;
        push_exp(4'd10, 32'hCAFE0010);
        push_exp(4'd11, 32'hCAFE0011);
        @(negedge clk);
        wb_valid = 1'b0;
        #1;
        checks += 2;
        if (pc_out !== 16'h1235) begin errors++; $display("FAIL pc_adv_idle: got %h expected %h", pc_out, 16'h1235); end
        if (busy !== 1'b1) begin errors++; $display("FAIL pc_busy: got %b expected 1", busy); end
        @(negedge clk);
        pc_advance = 1'b0;
        exp_pc = 16'h1236;
        #1;
        checks++;
        if (pc_out !== exp_pc) begin errors++; $display("FAIL pc_adv_wrhi: got %h expected %h", pc_out, exp_pc); end
        while (sb_q.size() > 0) begin
            @(negedge clk);
            e = sb_q.pop_front();
            rn_addr = e.addr;
            #1;
            checks++;
            if (rn_data !== e.data) begin errors++; $display("FAIL pc_reg[%0d]: got %h expected %h", e.addr, rn_data, e.data); end
        end
    endtask

    task automatic test_illegal();
        sb_t e;
        @(negedge clk);
        wb_valid = 1'b1; wb_sel = 2'b11; wb_rd = 4'd5; wb_data = 32'h0BADF00D;
        #1;
        checks++;
        if (illegal_sel !== 1'b0) begin errors++; $display("FAIL ill_before: got %b expected 0", illegal_sel); end
        push_exp(4'd5, model[5]);
        @(negedge clk);
        wb_valid = 1'b0;
        #1;
        checks += 2;
        if (illegal_sel !== 1'b1) begin errors++; $display("FAIL ill_pulse: got %b expected 1", illegal_sel); end
        if (pc_out !== exp_pc) begin errors++; $display("FAIL ill_pc: got %h expected %h", pc_out, exp_pc); end
        @(negedge clk);
        #1;
        checks++;
        if (illegal_sel !== 1'b0) begin errors++; $display("FAIL ill_after: got %b expected 0", illegal_sel); end
        while (sb_q.size() > 0) begin
            @(negedge clk);
            e = sb_q.pop_front();
            rn_addr = e.addr;
            #1;
            checks++;
            if (rn_data !== e.data) begin errors++; $display("FAIL ill_reg[%0d]: got %h expected %h", e.addr, rn_data, e.data); end
        end
    endtask

    task automatic test_reset_wr_hi();
        @(negedge clk);
        wb_valid = 1'b1; wb_sel = 2'b01; wb_rd = 4'd4; wb_rd_hi = 4'd6;
        wb_data = 32'h44444444; wb_data_hi = 32'h66666666;
        @(negedge clk);
        wb_valid = 1'b0; rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL rsthi_busy_before: got %b expected 1", busy); end
        @(negedge clk);
        rst = 1'b0;
        exp_pc = '0;
        for (int i = 0; i < 16; i++) model[i] = '0;
        #1;
        checks += 3;
        if (busy !== 1'b0) begin errors++; $display("FAIL rsthi_busy: got %b expected 0", busy); end
        if (wb_ready !== 1'b1) begin errors++; $display("FAIL rsthi_ready: got %b expected 1", wb_ready); end
        if (pc_out !== exp_pc) begin errors++; $display("FAIL rsthi_pc: got %h expected %h", pc_out, exp_pc); end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            rn_addr = 4'(i);
            #1;
            checks++;
            if (rn_data !== model[i]) begin errors++; $display("FAIL rsthi_reg[%0d]: got %h expected %h", i, rn_data, model[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_long_mul();
        test_pc();
        test_illegal();
        test_reset_wr_hi();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
